// File: rtl/escalonador_temporizador_pkg.sv
// Shared types and helpers for the interval-counter scheduler.
package escalonador_temporizador_pkg;

  localparam int unsigned StateW  = 2;
  localparam int unsigned DefCntW = 32;

  typedef enum logic [StateW-1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Rotation pointer advance, wrapping at the requester count.
  function automatic int unsigned next_ptr(input int unsigned cur, input int unsigned n);
    return (cur + 32'd1 >= n) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage

// File: rtl/escalonador_temporizador_arbitro_rr.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module escalonador_temporizador_arbitro_rr #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] winner_o
);

  // Scan ptr, ptr+1, ... modulo N_REQ and keep the first hit.
  always_comb begin
    int unsigned j;
    logic [IDX_W-1:0] jj;
    valid_o  = 1'b0;
    winner_o = '0;
    j        = 0;
    jj       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j  = (32'(ptr_i) + k) % N_REQ;
      jj = IDX_W'(j);
      if (!valid_o && req_i[jj]) begin
        valid_o  = 1'b1;
        winner_o = jj;
      end
    end
  end

endmodule

// File: rtl/escalonador_temporizador.sv
// Shares one interval counter among N_REQ requesters, granted round-robin.
module escalonador_temporizador
  import escalonador_temporizador_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = DefCntW,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic                   clk_i,
  input  logic                   sw_ni,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*CNT_W-1:0] dur_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic                   busy_o,
  output logic [N_REQ-1:0]       done_o,
  output logic [N_REQ-1:0]       abort_o,
  output logic [CNT_W-1:0]       tempo_o,
  output logic [IDX_W-1:0]       owner_o
);

  state_e             state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   limit_q;
  logic [CNT_W-1:0]   tempo_q;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   done_q;
  logic [N_REQ-1:0]   abort_q;
  logic               busy_q;

  logic               arb_valid;
  logic [IDX_W-1:0]   arb_winner;
  logic [CNT_W-1:0]   win_dur;
  logic [N_REQ-1:0]   win_oh;
  logic [IDX_W-1:0]   ptr_after;

  escalonador_temporizador_arbitro_rr #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arbitro_rr (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .valid_o  (arb_valid),
    .winner_o (arb_winner)
  );

  // Duration of the candidate winner and helpers for the FSM.
  always_comb begin
    win_dur   = CNT_W'(dur_i >> (32'(arb_winner) * CNT_W));
    win_oh    = N_REQ'(1) << arb_winner;
    ptr_after = IDX_W'(next_ptr(32'(owner_q), N_REQ));
  end

  // Scheduler FSM with counter, pointer and registered outputs.
  always_ff @(posedge clk_i or negedge sw_ni) begin
    if (!sw_ni) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= '0;
      limit_q <= '0;
      tempo_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      abort_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      done_q  <= '0;
      abort_q <= '0;
      unique case (state_q)
        StIdle: begin
          tempo_q <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
          if (arb_valid) begin
            owner_q <= arb_winner;
            limit_q <= win_dur;
            grant_q <= win_oh;
            busy_q  <= 1'b1;
            if (win_dur == '0) begin
              // Zero-length interval completes without any RUN cycle.
              state_q <= StDone;
              done_q  <= win_oh;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          // Completion wins over a cancel seen in the same cycle.
          if (tempo_q == limit_q - CNT_W'(1)) begin
            state_q <= StDone;
            done_q  <= grant_q;
          end else if (!req_i[owner_q]) begin
            state_q <= StIdle;
            abort_q <= grant_q;
            grant_q <= '0;
            busy_q  <= 1'b0;
            tempo_q <= '0;
            ptr_q   <= ptr_after;
          end else begin
            tempo_q <= tempo_q + CNT_W'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          grant_q <= '0;
          busy_q  <= 1'b0;
          tempo_q <= '0;
          ptr_q   <= ptr_after;
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
          busy_q  <= 1'b0;
          tempo_q <= '0;
        end
      endcase
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign abort_o = abort_q;
  assign tempo_o = tempo_q;
  assign owner_o = owner_q;

endmodule
